// File: rtl/rx78_cart_arbiter.sv
// RX-78 cartridge/EXT RAM arbiter: HPS download writes and Z80 bus share one BRAM.
// Define RX78_CART_WP_EN to write-protect the cartridge window against CPU writes.
module rx78_cart_arbiter #(
  parameter int          AW         = 15,
  parameter logic [15:0] CART_BASE  = 16'h2000,
  parameter logic [15:0] CART_SIZE  = 16'h4000,
  parameter logic [15:0] EXT_BASE   = 16'h6000,
  parameter logic [7:0]  CART_INDEX = 8'd1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [7:0]    dl_index,
  input  logic [24:0]   dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          ext,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [15:0]   cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_wait,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  output logic [15:0]   cart_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DLW,
    S_CPU_RD,
    S_CPU_RD2,
    S_CPU_DONE
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_dl_addr;
  logic [7:0]    r_dl_data;
  logic          r_dl_pend;
  logic          r_dl_active;
  logic [15:0]   r_cart_len;
  logic [7:0]    r_cpu_rdata;
  logic          r_cpu_ack;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_we;
  logic [7:0]    r_mem_din;

  logic          w_dl_acc;
  logic          w_dl_rise;
  logic [15:0]   w_len_base;
  logic [15:0]   w_dl_len;
  logic [15:0]   w_cart_off;
  logic [15:0]   w_ext_off;
  logic          w_in_cart;
  logic          w_in_ext;
  logic          w_mapped;
  logic [AW-1:0] w_cpu_off;
  logic          w_wr_ok;
  logic          w_port_free;
  logic          w_dl_take;
  logic          w_grant;

  assign w_dl_acc   = dl_wr && (dl_index == CART_INDEX)
                   && (dl_addr < {9'd0, CART_SIZE});
  assign w_dl_rise  = dl_active & ~r_dl_active;
  assign w_len_base = w_dl_rise ? 16'd0 : r_cart_len;
  assign w_dl_len   = dl_addr[15:0] + 16'd1;

  // Window tests in mod-2^16 offset form also cover a window that wraps.
  assign w_cart_off = cpu_addr - CART_BASE;
  assign w_ext_off  = cpu_addr - EXT_BASE;
  assign w_in_cart  = w_cart_off < CART_SIZE;
  assign w_in_ext   = ext && (w_ext_off < CART_SIZE);
  assign w_mapped   = w_in_cart | w_in_ext;
  assign w_cpu_off  = w_in_cart ? AW'(w_cart_off)
                                : AW'(CART_SIZE + w_ext_off);

`ifdef RX78_CART_WP_EN
  assign w_wr_ok = w_mapped & ~w_in_cart;
`else
  assign w_wr_ok = w_mapped;
`endif

  assign w_port_free = (r_state == S_IDLE) || (r_state == S_DLW)
                    || (r_state == S_CPU_DONE);
  assign w_dl_take   = r_dl_pend & w_port_free;
  // An accepted byte arriving this cycle also blocks the grant: download first.
  assign w_grant     = cpu_req & ~r_dl_pend & ~w_dl_acc & ~dl_active;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dl_addr   <= '0;
      r_dl_data   <= 8'h00;
      r_dl_pend   <= 1'b0;
      r_dl_active <= 1'b0;
      r_cart_len  <= 16'd0;
      r_cpu_rdata <= 8'hFF;
      r_cpu_ack   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_din   <= 8'h00;
    end else begin
      r_dl_active <= dl_active;
      r_mem_we    <= 1'b0;
      r_cpu_ack   <= 1'b0;

      if (w_dl_acc) begin
        r_dl_addr  <= AW'(dl_addr);
        r_dl_data  <= dl_data;
        r_cart_len <= (w_dl_len > w_len_base) ? w_dl_len : w_len_base;
      end else if (w_dl_rise) begin
        r_cart_len <= 16'd0;
      end

      r_dl_pend <= w_dl_acc | (r_dl_pend & ~w_dl_take);

      unique case (r_state)
        S_IDLE, S_DLW, S_CPU_DONE: begin
          if (w_dl_take) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_dl_addr;
            r_mem_din  <= r_dl_data;
            r_state    <= S_DLW;
          end else if ((r_state == S_IDLE) && w_grant) begin
            if (!w_mapped) begin
              r_cpu_ack <= 1'b1;
              if (!cpu_we) r_cpu_rdata <= 8'hFF;
              r_state <= S_CPU_DONE;
            end else if (cpu_we) begin
              r_mem_we   <= w_wr_ok;
              r_mem_addr <= w_cpu_off;
              r_mem_din  <= cpu_wdata;
              r_cpu_ack  <= 1'b1;
              r_state    <= S_CPU_DONE;
            end else begin
              r_mem_addr <= w_cpu_off;
              r_state    <= S_CPU_RD;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CPU_RD: r_state <= S_CPU_RD2;
        S_CPU_RD2: begin
          r_cpu_rdata <= mem_dout;
          r_cpu_ack   <= 1'b1;
          r_state     <= S_CPU_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ack   = r_cpu_ack;
  assign cpu_wait  = cpu_req & ~r_cpu_ack;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_din   = r_mem_din;
  assign cart_len  = r_cart_len;

endmodule

// File: tb/tb_rx78_cart_arbiter.sv
// Bench for rx78_cart_arbiter: RAM model, memory-write scoreboard, CPU access table.
module tb_rx78_cart_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        dl_active, dl_wr, ext, cpu_req, cpu_we;
  logic [7:0]  dl_index, dl_data, cpu_wdata;
  logic [24:0] dl_addr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack, cpu_wait;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [15:0] cart_len;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  ram [32768];
  logic [22:0] sb [$];

  always #5 clk = ~clk;

  rx78_cart_arbiter dut (
    .clk(clk), .reset(reset),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_index(dl_index),
    .dl_addr(dl_addr), .dl_data(dl_data), .ext(ext),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cpu_wait(cpu_wait), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_dout(mem_dout), .cart_len(cart_len)
  );

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
    mem_dout = 8'h00;
  end

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every memory write cycle must match the next expected write in order.
  always @(negedge clk) begin
    if (mem_we) begin
      if (sb.size() == 0) begin
        chk("memwr_unexpected", {9'd0, mem_addr, mem_din}, 32'h0);
        n_chk--;
        if (mem_addr == 15'd0 && mem_din == 8'd0) begin
          n_err++;
          $display("FAIL memwr_unexpected: got a0 d0 expected none");
        end
      end else begin
        chk("memwr", {9'd0, mem_addr, mem_din}, {9'd0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dl_write(input logic [7:0] idx, input logic [24:0] a,
                          input logic [7:0] d);
    dl_wr = 1'b1; dl_index = idx; dl_addr = a; dl_data = d;
    if (idx == 8'd1 && a < 25'h4000) sb.push_back({a[14:0], d});
    tick();
    dl_wr = 1'b0;
  endtask

  task automatic cpu_access(input string nm, input logic we,
                            input logic ex, input logic [15:0] a,
                            input logic [7:0] wd, input logic [7:0] exp_rd,
                            input logic chkma, input logic [14:0] ma,
                            input int lat);
    int  n;
    bit  got;
    bit  wait_ok;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; ext = ex;
    if (we && chkma) sb.push_back({ma, wd});
    n = 0; got = 0; wait_ok = 1;
    while (!got && n < 20) begin
      tick();
      dl_wr = 1'b0;
      n++;
      if (cpu_ack) got = 1;
      else if (!cpu_wait) wait_ok = 0;
    end
    chk({nm, ".ack"}, {31'd0, got}, 32'd1);
    chk({nm, ".wait"}, {31'd0, wait_ok}, 32'd1);
    if (got) begin
      if (lat != 0) chk({nm, ".lat"}, n, lat);
      if (!we) chk({nm, ".rdata"}, {24'd0, cpu_rdata}, {24'd0, exp_rd});
      if (chkma) chk({nm, ".maddr"}, {17'd0, mem_addr}, {17'd0, ma});
      chk({nm, ".wait_at_ack"}, {31'd0, cpu_wait}, 32'd0);
    end
    cpu_req = 1'b0;
    tick();
  endtask

  typedef struct {
    string       nm;
    logic        we;
    logic        ex;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  rd;
    logic        chkma;
    logic [14:0] ma;
    int          lat;
  } vec_t;

  vec_t tv [13];
  logic [7:0] cart0;
  bit got_ack;
  int n;

  initial begin
    tv[0]  = '{"rd2001",    0, 0, 16'h2001, 8'h00, 8'hA1, 1, 15'h0001, 3};
    tv[1]  = '{"rd2000",    0, 0, 16'h2000, 8'h00, 8'hA0, 1, 15'h0000, 3};
    tv[2]  = '{"rd2003",    0, 1, 16'h2003, 8'h00, 8'hA3, 1, 15'h0003, 3};
    tv[3]  = '{"wr6005",    1, 1, 16'h6005, 8'h5A, 8'h00, 1, 15'h4005, 1};
    tv[4]  = '{"rd6005",    0, 1, 16'h6005, 8'h00, 8'h5A, 1, 15'h4005, 3};
    tv[5]  = '{"rd6005_nx", 0, 0, 16'h6005, 8'h00, 8'hFF, 0, 15'h0000, 1};
    tv[6]  = '{"wr6005_nx", 1, 0, 16'h6005, 8'h33, 8'h00, 0, 15'h0000, 1};
    tv[7]  = '{"rd6005_b",  0, 1, 16'h6005, 8'h00, 8'h5A, 1, 15'h4005, 3};
    tv[8]  = '{"rd1fff",    0, 1, 16'h1FFF, 8'h00, 8'hFF, 0, 15'h0000, 1};
    tv[9]  = '{"rd5fff",    0, 0, 16'h5FFF, 8'h00, 8'h5C, 1, 15'h3FFF, 3};
    tv[10] = '{"rd6000_nx", 0, 0, 16'h6000, 8'h00, 8'hFF, 0, 15'h0000, 1};
    tv[11] = '{"wr9fff",    1, 1, 16'h9FFF, 8'hC3, 8'h00, 1, 15'h7FFF, 1};
    tv[12] = '{"rda000_nx", 0, 1, 16'hA000, 8'h00, 8'hFF, 0, 15'h0000, 1};

    reset = 1'b1; dl_active = 0; dl_wr = 0; dl_index = 0; dl_addr = 0;
    dl_data = 0; ext = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0;
    cpu_wdata = 0;
    tick(); tick();
    chk("rst.rdata", {24'd0, cpu_rdata}, 32'hFF);
    chk("rst.ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst.mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst.maddr", {17'd0, mem_addr}, 32'd0);
    chk("rst.cart_len", {16'd0, cart_len}, 32'd0);
    reset = 1'b0;
    tick();

    dl_active = 1'b1;
    tick();
    dl_write(8'd1, 25'd0, 8'hA0);
    dl_write(8'd1, 25'd1, 8'hA1);
    dl_write(8'd1, 25'd2, 8'hA2);
    dl_write(8'd1, 25'd3, 8'hA3);
    chk("dl.len4", {16'd0, cart_len}, 32'd4);
    tick();
    dl_write(8'd1, 25'h4000, 8'hEE);
    chk("dl.len_oob", {16'd0, cart_len}, 32'd4);
    dl_write(8'd2, 25'd0, 8'hEE);
    chk("dl.len_idx", {16'd0, cart_len}, 32'd4);
    dl_write(8'd1, 25'h3FFF, 8'h5C);
    chk("dl.len_top", {16'd0, cart_len}, 32'h4000);
    dl_active = 1'b0;
    repeat (4) tick();
    chk("dl.drained", sb.size(), 0);

    for (int i = 0; i < 13; i++)
      cpu_access(tv[i].nm, tv[i].we, tv[i].ex, tv[i].a, tv[i].wd,
                 tv[i].rd, tv[i].chkma, tv[i].ma, tv[i].lat);

`ifdef RX78_CART_WP_EN
    cpu_access("wr2000_wp", 1, 0, 16'h2000, 8'h77, 8'h00, 0, 15'h0, 1);
    cart0 = 8'hA0;
`else
    cpu_access("wr2000", 1, 0, 16'h2000, 8'h77, 8'h00, 1, 15'h0, 1);
    cart0 = 8'h77;
`endif
    cpu_access("rd2000_b", 0, 0, 16'h2000, 8'h00, cart0, 1, 15'h0, 3);

    // CPU stays stalled for the whole download window.
    dl_active = 1'b1;
    tick();
    chk("dl2.len_clr", {16'd0, cart_len}, 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000; ext = 1'b0;
    got_ack = 0;
    repeat (5) begin
      tick();
      if (cpu_ack) got_ack = 1;
    end
    chk("stall.no_ack", {31'd0, got_ack}, 32'd0);
    chk("stall.wait", {31'd0, cpu_wait}, 32'd1);
    dl_active = 1'b0;
    n = 0;
    while (!cpu_ack && n < 20) begin
      tick();
      n++;
    end
    chk("stall.ack", {31'd0, cpu_ack}, 32'd1);
    chk("stall.rdata", {24'd0, cpu_rdata}, {24'd0, cart0});
    cpu_req = 1'b0;
    tick();

    // Same-cycle download byte and CPU write: download lands first.
    dl_wr = 1'b1; dl_index = 8'd1; dl_addr = 25'd2; dl_data = 8'h99;
    sb.push_back({15'd2, 8'h99});
    cpu_access("sim_wr6010", 1, 1, 16'h6010, 8'hE1, 8'h00, 1, 15'h4010, 0);
    chk("sim.len", {16'd0, cart_len}, 32'd3);
    cpu_access("sim_rd2002", 0, 0, 16'h2002, 8'h00, 8'h99, 1, 15'h0002, 3);
    cpu_access("sim_rd6010", 0, 1, 16'h6010, 8'h00, 8'hE1, 1, 15'h4010, 3);

    // Reset while a read is in CPU_RD.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2001; ext = 1'b0;
    tick();
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    chk("rst2.ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst2.rdata", {24'd0, cpu_rdata}, 32'hFF);
    chk("rst2.maddr", {17'd0, mem_addr}, 32'd0);
    chk("rst2.mem_din", {24'd0, mem_din}, 32'd0);
    chk("rst2.cart_len", {16'd0, cart_len}, 32'd0);
    reset = 1'b0;
    got_ack = 0;
    repeat (4) begin
      tick();
      if (cpu_ack) got_ack = 1;
    end
    chk("rst2.no_ack", {31'd0, got_ack}, 32'd0);
    chk("end.sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
